mix_columns_engine: RTL and testbench
=====================================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 The block SHALL have no parameters; width is fixed at one 128-bit AES state.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  in_state/in_bypass are valid.
REQ-005 in_ready  output  1  engine can accept a new state.
REQ-006 in_state  input  128  AES state; byte s(r,c) at bits [127-8*(4c+r) -: 8] (column-major, s(0,0) in MSBs).
REQ-007 in_bypass  input  1  1 = final round, pass state through unmixed.
REQ-008 out_valid  output  1  out_state is valid.
REQ-009 out_ready  input  1  consumer accepts out_state.
REQ-010 out_state  output  128  MixColumns result, same byte layout as in_state.

Function
REQ-011 The block SHALL implement forward AES MixColumns per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-012 Multiply-by-2 SHALL be {a[6:0],1'b0} XOR (a[7] ? 8'h1B : 8'h00); multiply-by-3 SHALL be (2a)^a; all arithmetic 8-bit GF(2^8), no carries.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; one-hot or binary encoding is free.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on in_valid&&in_ready at edge N, latch in_state into working register, latch in_bypass, clear column counter to 0, go BUSY.
REQ-016 BUSY: exactly one column per cycle, column c at edge N+1+c (c=0..3); counter 2 bits, wraps 3->0 on leaving BUSY.
REQ-017 After edge N+4 the state SHALL be DONE with out_valid=1; fixed latency 4 cycles, independent of in_bypass.
REQ-018 With bypass latched, each column SHALL be written back unchanged in the same cycle slots.
REQ-019 DONE: out_state and out_valid SHALL hold stable until out_valid&&out_ready; on that edge go IDLE.
REQ-020 No input acceptance in the same cycle as output handshake; next accept earliest one cycle later (throughput one state per 6 cycles minimum).
REQ-021 in_valid/in_state changes during BUSY or DONE SHALL be ignored; out_ready during IDLE or BUSY SHALL be ignored.
REQ-022 out_state SHALL be driven directly from the working register (registered output, no combinational path from inputs).

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, column counter 0, bypass flag 0, working register 128'h0, regardless of current state.
REQ-024 During and after reset: in_ready=1 (IDLE), out_valid=0, out_state=128'h0.
REQ-025 Reset mid-BUSY or mid-DONE SHALL discard the in-flight state with no output handshake.

Structure
REQ-026 Shared package SHALL hold the FSM state enumeration, GF reduction constant 8'h1B, state width 128 and column count 4.
REQ-027 One combinational sub-module, mix_single_column (32-bit column in, 32-bit column out), SHALL be instantiated once and muxed by the column counter; it reuses the existing mul2 multiplier.

Verification
REQ-028 Column db 13 53 45 (other columns 01 01 01 01), bypass=0 -> out columns 8e 4d a1 bc, 01 01 01 01 ..., out_valid 4 cycles after accept.
REQ-029 Full state with columns f2 0a 22 5c / d4 d4 d4 d5 / 2d 26 31 4c / c6 c6 c6 c6 -> 9f dc 58 9d / d5 d5 d7 d6 / 4d 7e bd f8 / c6 c6 c6 c6.
REQ-030 Same state with in_bypass=1 -> out_state identical to in_state, latency still 4.
REQ-031 Hold out_ready=0 for 10 cycles in DONE, toggle in_valid/in_state -> out_state stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-032 Assert rst_n=0 at BUSY cycle 2 -> next cycle IDLE, out_valid=0, out_state=0; following accept produces correct result.
REQ-033 Back-to-back: in_valid held high, out_ready held high -> accepts spaced exactly 6 cycles, each output matches golden model.

Source files
------------

// File: rtl/mix_columns_engine_pkg.sv
// mix_columns_engine_pkg: shared FSM encoding, AES field constants and GF(2^8) doubling.
package mix_columns_engine_pkg;
    localparam int STATE_W = 128;
    localparam int COLS = 4;
    localparam int COL_W = $clog2(COLS);
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    function automatic logic [7:0] mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mix_columns_engine_column.sv
// mix_single_column: forward AES MixColumns on one 32-bit column, row 0 in the MSBs.
module mix_single_column
    import mix_columns_engine_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;

    assign {a0, a1, a2, a3} = col_i;
    assign d0 = mul2(a0);
    assign d1 = mul2(a1);
    assign d2 = mul2(a2);
    assign d3 = mul2(a3);
    // 3a is expressed as 2a ^ a, so each output is 2x one byte ^ 2x the next ^ the rest
    assign col_o = {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                    a0 ^ d1 ^ d2 ^ a2 ^ a3,
                    a0 ^ a1 ^ d2 ^ d3 ^ a3,
                    d0 ^ a0 ^ a1 ^ a2 ^ d3};
endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: one AES state per transaction, one column mixed per cycle through a shared datapath.
module mix_columns_engine
    import mix_columns_engine_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);
    fsm_e               state_q;
    logic [STATE_W-1:0] work_q;
    logic [COL_W-1:0]   col_q;
    logic               byp_q, in_ready_q, out_valid_q;
    logic [6:0]         base;
    logic [31:0]        col_cur, col_mix, col_d;

    assign base = 7'd127 - {col_q, 5'd0};
    assign col_cur = work_q[base -: 32];
    assign col_d = byp_q ? col_cur : col_mix;

    mix_single_column u_mix (
        .col_i(col_cur),
        .col_o(col_mix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q <= '0;
            col_q <= '0;
            byp_q <= 1'b0;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q <= in_state;
                    byp_q <= in_bypass;
                    col_q <= '0;
                    state_q <= BUSY;
                    in_ready_q <= 1'b0;
                end
                BUSY: begin
                    // bypass still spends the slot so latency never depends on it
                    work_q[base -: 32] <= col_d;
                    col_q <= col_q + COL_W'(1);
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_q <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    in_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = work_q;
endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: directed-vector bench for the MixColumns engine.
module tb_mix_columns_engine;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bypass = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready, out_valid;
    logic [127:0] out_state;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    mix_columns_engine dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_state(in_state),
        .in_bypass(in_bypass),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        chk("ready_before_accept", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_state = vecs[i].st;
        in_bypass = vecs[i].byp;
        @(negedge clk);
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'($urandom);
        wait_out(lat);
        chk($sformatf("latency_v%0d", i), 128'(lat), 128'd4);
        chk($sformatf("out_state_v%0d", i), out_state, vecs[i].exp);
        chk("in_ready_done", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_hs", 128'(out_valid), 128'd0);
        chk("in_ready_after_hs", 128'(in_ready), 128'd1);
    endtask

    initial begin
        int lat, w;
        int acc[4];
        logic [127:0] held;
        vecs[0] = '{128'hdb135345_01010101_01010101_01010101, 1'b0, 128'h8e4da1bc_01010101_01010101_01010101};
        vecs[1] = '{128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6, 1'b0, 128'h9fdc589d_d5d5d7d6_4d7ebdf8_c6c6c6c6};
        vecs[2] = '{128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6, 1'b1, 128'hf20a225c_d4d4d4d5_2d26314c_c6c6c6c6};
        vecs[3] = '{128'h6347a2f0_db135345_01010101_c6c6c6c6, 1'b0, 128'h5de070bb_8e4da1bc_01010101_c6c6c6c6};
        vecs[4] = '{128'h6347a2f0_db135345_01010101_c6c6c6c6, 1'b1, 128'h6347a2f0_db135345_01010101_c6c6c6c6};
        vecs[5] = '{128'h0, 1'b0, 128'h0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_state", out_state, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i);

        // stall in DONE while upstream wiggles its inputs
        in_valid = 1'b1;
        in_state = vecs[3].st;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("hold_latency", 128'(lat), 128'd4);
        held = out_state;
        chk("hold_first", held, vecs[3].exp);
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk($sformatf("hold_state_%0d", k), out_state, held);
            chk($sformatf("hold_valid_%0d", k), 128'(out_valid), 128'd1);
            chk($sformatf("hold_ready_%0d", k), 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_ready", 128'(in_ready), 128'd1);
        chk("hold_release_valid", 128'(out_valid), 128'd0);

        // reset while mixing column 2
        in_valid = 1'b1;
        in_state = vecs[1].st;
        in_bypass = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_state", out_state, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(1);

        // streaming with both handshakes held high
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("b2b_ready_timeout_%0d", k), 128'(w < 20), 128'd1);
            in_state = vecs[k].st;
            in_bypass = vecs[k].byp;
            acc[k] = cyc;
            @(negedge clk);
            wait_out(lat);
            chk($sformatf("b2b_latency_%0d", k), 128'(lat), 128'd4);
            chk($sformatf("b2b_state_%0d", k), out_state, vecs[k].exp);
            if (k > 0) chk($sformatf("b2b_spacing_%0d", k), 128'(acc[k] - acc[k-1]), 128'd6);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle_end", 128'(in_ready), 128'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
